// File: rtl/keyboard_renderer_if.sv
// keyboard_renderer_if: key levels in, pixel stream and frame status out
interface keyboard_renderer_if #(parameter int NUM_KEYS = 4);
  logic [NUM_KEYS-1:0] i_keys;
  logic [2:0]          o_colour;
  logic [7:0]          o_x;
  logic [6:0]          o_y;
  logic                o_plot;
  logic                o_busy;
  logic                o_frame_done;
  modport master (input i_keys, output o_colour, o_x, o_y, o_plot, o_busy, o_frame_done);
  modport slave (output i_keys, input o_colour, o_x, o_y, o_plot, o_busy, o_frame_done);
endinterface

// File: rtl/keyboard_renderer.sv
// keyboard_renderer: rasterises a row of on-screen keys, redrawing when the held keys change
module keyboard_renderer #(
  parameter int          NUM_KEYS     = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  PRESS_COLOUR = 3'b100,
  parameter logic [2:0]  IDLE_COLOUR  = 3'b111
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  keyboard_renderer_if.master  bus
);
  localparam int         KEY_W = SCREEN_W / NUM_KEYS;
  localparam logic [7:0] XM    = 8'(SCREEN_W - 1);
  localparam logic [6:0] YM    = 7'(SCREEN_H - 1);
  localparam logic [7:0] CM    = 8'(KEY_W - 1);
  localparam logic [4:0] KN    = 5'(NUM_KEYS);
  localparam logic [4:0] KL    = 5'(NUM_KEYS - 1);
  typedef enum logic {IDLE, DRAW} state_t;
  state_t              r_state, w_state_next;
  logic [NUM_KEYS-1:0] r_kl, w_kl;
  logic [7:0]          r_x, w_nx, r_col, w_ncol;
  logic [6:0]          r_y, w_ny;
  logic [4:0]          r_k, w_nk;
  logic [2:0]          r_colour, w_colour;
  logic                r_plot, r_fd;
  logic                w_start, w_last, w_emit, w_hit;
  logic [31:0]         w_pad;
  // DRAW with plot low only occurs straight after reset and means "start a frame now"
  always_comb begin
    w_start      = (r_state == IDLE) ? (bus.i_keys != r_kl) : !r_plot;
    w_last       = r_state == DRAW && r_plot && r_x == XM && r_y == YM;
    w_emit       = w_start || (r_state == DRAW && r_plot && !w_last);
    w_state_next = w_start ? DRAW : w_last ? IDLE : r_state;
    w_kl         = w_start ? bus.i_keys : r_kl;
    w_nx         = (w_start || r_x == XM) ? 8'd0 : r_x + 8'd1;
    w_ny         = w_start ? 7'd0 : (r_x != XM) ? r_y : (r_y == YM) ? 7'd0 : r_y + 7'd1;
    w_ncol       = (w_start || r_x == XM || r_col == CM) ? 8'd0 : r_col + 8'd1;
    w_nk         = (w_start || r_x == XM) ? 5'd0 : (r_col == CM) ? r_k + 5'd1 : r_k;
    w_pad        = 32'(w_kl);
    w_hit        = w_pad[w_nk];
    w_colour     = (w_nk >= KN || (w_ncol == CM && w_nk < KL)) ? 3'b000 : w_hit ? PRESS_COLOUR : IDLE_COLOUR;
  end
  // state register; reset leaves the FSM pending a fresh frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= DRAW;
    else          r_state <= w_state_next;
  end
  // pixel pipeline: counters and outputs advance only when a pixel is emitted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_kl     <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_plot <= w_emit;
      r_fd   <= w_emit && w_nx == XM && w_ny == YM;
      if (w_emit) begin
        r_x      <= w_nx;
        r_y      <= w_ny;
        r_col    <= w_ncol;
        r_k      <= w_nk;
        r_colour <= w_colour;
      end
      if (w_start) r_kl <= bus.i_keys;
    end
  end
  assign bus.o_x          = r_x;
  assign bus.o_y          = r_y;
  assign bus.o_colour     = r_colour;
  assign bus.o_plot       = r_plot;
  assign bus.o_busy       = r_plot;
  assign bus.o_frame_done = r_fd;
endmodule

// File: tb/tb_keyboard_renderer.sv
// tb_keyboard_renderer: directed frames on a default renderer plus a three-key column check
module tb_keyboard_renderer;
  localparam int W = 160;
  localparam int H = 120;
  typedef struct {int fr; int sel; int x; logic [2:0] exp;} vec_t;
  logic clk = 1'b0;
  logic rst_n;
  keyboard_renderer_if #(.NUM_KEYS(4)) bus ();
  keyboard_renderer_if #(.NUM_KEYS(3)) bus3 ();
  keyboard_renderer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  keyboard_renderer #(.NUM_KEYS(3), .SCREEN_W(160), .SCREEN_H(2)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int pc, fd_cnt, fd_bad, order_err, col_err;
  logic [3:0] exp_kl;
  logic [2:0] line [0:W-1];
  logic [2:0] snap [0:W-1];
  logic [2:0] line3 [0:W-1];
  vec_t tab [29];
  function automatic logic [2:0] ref_col(int x, logic [15:0] kl, int nk, int kw);
    int k;
    k = x / kw;
    if (k >= nk) return 3'b000;
    if (x % kw == kw - 1 && k < nk - 1) return 3'b000;
    return kl[k] ? 3'b100 : 3'b111;
  endfunction
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.o_busy != bus.o_plot) order_err++;
    if (bus.o_plot) begin
      if (bus.o_x != 8'(pc % W) || bus.o_y != 7'(pc / W)) order_err++;
      if (bus.o_colour != ref_col(int'(bus.o_x), 16'(exp_kl), 4, 40)) col_err++;
      line[bus.o_x] = bus.o_colour;
      if (bus.o_frame_done) begin
        fd_cnt++;
        if (pc != W * H - 1) fd_bad++;
      end
      pc++;
    end else if (bus.o_frame_done) fd_bad++;
    if (bus3.o_plot) line3[bus3.o_x] = bus3.o_colour;
  end
  task automatic clr();
    pc = 0;
    order_err = 0;
    col_err = 0;
    fd_bad = 0;
  endtask
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  task automatic wait_pc(int target);
    int n = 0;
    while (pc < target && n < 25000) begin
      tick();
      n++;
    end
    chk("reach_pixel", int'(pc >= target), 1);
  endtask
  task automatic wait_fd();
    int s = fd_cnt;
    int n = 0;
    while (fd_cnt == s && n < 25000) begin
      tick();
      n++;
    end
    chk("frame_done_seen", fd_cnt, s + 1);
    snap = line;
  endtask
  task automatic frame_ok(string tag);
    chk({tag, "_pixels"}, pc, W * H);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_colour"}, col_err, 0);
    chk({tag, "_fd_pos"}, fd_bad, 0);
  endtask
  task automatic check_tab(int f);
    for (int i = 0; i < 29; i++)
      if (tab[i].fr == f)
        chk($sformatf("f%0d_dut%0d_x%0d", f, tab[i].sel, tab[i].x),
            int'(tab[i].sel == 1 ? line3[tab[i].x] : snap[tab[i].x]), int'(tab[i].exp));
  endtask
  initial begin
    int f0, p;
    tab = '{
      '{1,0,0,3'd7}, '{1,0,38,3'd7}, '{1,0,39,3'd0}, '{1,0,40,3'd7},
      '{1,0,79,3'd0}, '{1,0,119,3'd0}, '{1,0,120,3'd7}, '{1,0,159,3'd7},
      '{1,1,51,3'd7}, '{1,1,52,3'd0}, '{1,1,53,3'd7}, '{1,1,105,3'd0},
      '{1,1,106,3'd7}, '{1,1,158,3'd7}, '{1,1,159,3'd0},
      '{2,0,79,3'd0}, '{2,0,80,3'd4}, '{2,0,118,3'd4}, '{2,0,119,3'd0},
      '{2,0,120,3'd7}, '{2,0,159,3'd7}, '{2,0,0,3'd7}, '{2,0,38,3'd7},
      '{3,0,0,3'd4}, '{3,0,38,3'd4}, '{3,0,39,3'd0}, '{3,0,40,3'd7},
      '{3,0,80,3'd4}, '{3,0,119,3'd0}
    };
    fd_cnt = 0;
    clr();
    exp_kl = 4'b0000;
    bus.i_keys = 4'b0000;
    bus3.i_keys = 3'b000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_plot", int'(bus.o_plot), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_fd", int'(bus.o_frame_done), 0);
    chk("rst_x", int'(bus.o_x), 0);
    chk("rst_y", int'(bus.o_y), 0);
    chk("rst_colour", int'(bus.o_colour), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_pc(10000);
    rst_n = 1'b0;
    #1;
    chk("abort_plot", int'(bus.o_plot), 0);
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_x", int'(bus.o_x), 0);
    chk("abort_y", int'(bus.o_y), 0);
    chk("abort_colour", int'(bus.o_colour), 0);
    p = pc;
    repeat (3) tick();
    chk("abort_no_plots", pc, p);
    clr();
    f0 = fd_cnt;
    rst_n = 1'b1;
    wait_fd();
    frame_ok("f1");
    repeat (5) tick();
    chk("f1_fd_once", fd_cnt - f0, 1);
    chk("idle_plot", int'(bus.o_plot), 0);
    chk("idle_busy", int'(bus.o_busy), 0);
    chk("idle_x_hold", int'(bus.o_x), W - 1);
    chk("idle_y_hold", int'(bus.o_y), H - 1);
    chk("idle_no_redraw", pc, W * H);
    check_tab(1);
    clr();
    exp_kl = 4'b0100;
    bus.i_keys = 4'b0100;
    wait_pc(5000);
    bus.i_keys = 4'b0101;
    wait_fd();
    frame_ok("f2");
    clr();
    exp_kl = 4'b0101;
    tick();
    chk("gap_plot", int'(bus.o_plot), 0);
    tick();
    chk("restart_plot", int'(bus.o_plot), 1);
    chk("restart_x", int'(bus.o_x), 0);
    chk("restart_y", int'(bus.o_y), 0);
    check_tab(2);
    wait_pc(3000);
    bus.i_keys = 4'b0111;
    wait_pc(6000);
    bus.i_keys = 4'b0101;
    wait_fd();
    frame_ok("f3");
    check_tab(3);
    clr();
    repeat (30) tick();
    chk("pulse_no_redraw", pc, 0);
    chk("pulse_busy", int'(bus.o_busy), 0);
    chk("pulse_plot", int'(bus.o_plot), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
